// File: rtl/spi_subperipheral_if.sv
// Byte-level command interface plus the SPI pins of the subperipheral.
// The slave modport is the subperipheral's view. The master modport is the
// view of the host pins together with the command block.
interface spi_subperipheral_if;
    logic        spi_select_in;
    logic        spi_clock_in;
    logic        spi_data_in;
    logic        spi_data_out;
    logic [7:0]  op_code_out;
    logic        op_code_valid_out;
    logic [7:0]  operand_out;
    logic        operand_valid_out;
    logic [31:0] operand_count_out;
    logic [7:0]  response_in;
    logic        response_valid_in;

    modport slave (
        input  spi_select_in,
        input  spi_clock_in,
        input  spi_data_in,
        output spi_data_out,
        output op_code_out,
        output op_code_valid_out,
        output operand_out,
        output operand_valid_out,
        output operand_count_out,
        input  response_in,
        input  response_valid_in
    );

    modport master (
        output spi_select_in,
        output spi_clock_in,
        output spi_data_in,
        input  spi_data_out,
        input  op_code_out,
        input  op_code_valid_out,
        input  operand_out,
        input  operand_valid_out,
        input  operand_count_out,
        output response_in,
        output response_valid_in
    );
endinterface

// File: rtl/spi_subperipheral.sv
// SPI mode-0 subperipheral. It oversamples the host pins in the SPI clock
// domain, frames the first byte of a transaction as an op-code and later
// bytes as operands, and shifts the command block's response byte out on
// CIPO during the byte that follows.
module spi_subperipheral #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [7:0]  IDLE_RESPONSE = 8'h00
) (
    input logic                clock_spi_in,
    input logic                reset_spi_in,
    spi_subperipheral_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        OPCODE        = 2'd1,
        OPERAND       = 2'd2,
        WAIT_DESELECT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] select_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic                   select_prev;
    logic                   sck_prev;

    logic select_now;
    logic sck_now;
    logic copi_now;
    logic select_fall;
    logic select_rise;
    logic sck_rise;
    logic sck_fall;

    logic        receiving;
    logic        in_opcode;
    logic        start;
    logic        byte_done;
    logic [7:0]  rx_byte;

    logic [6:0]  rx_shift;
    logic [2:0]  bit_count;
    logic [7:0]  tx_shift;
    logic        load_pending;
    logic [7:0]  op_code;
    logic        op_code_valid;
    logic [7:0]  operand;
    logic        operand_valid;
    logic [31:0] operand_count;

    // Pin synchronisers and edge-detect history. These are left out of reset
    // so the synchronised select is already valid when reset releases.
    always_ff @(posedge clock_spi_in) begin
        select_sync <= {select_sync[SYNC_STAGES-2:0], bus.spi_select_in};
        sck_sync    <= {sck_sync[SYNC_STAGES-2:0], bus.spi_clock_in};
        copi_sync   <= {copi_sync[SYNC_STAGES-2:0], bus.spi_data_in};
        select_prev <= select_sync[SYNC_STAGES-1];
        sck_prev    <= sck_sync[SYNC_STAGES-1];
    end

    assign select_now  = select_sync[SYNC_STAGES-1];
    assign sck_now     = sck_sync[SYNC_STAGES-1];
    assign copi_now    = copi_sync[SYNC_STAGES-1];
    assign select_fall = select_prev & ~select_now;
    assign select_rise = ~select_prev & select_now;
    assign sck_rise    = ~sck_prev & sck_now;
    assign sck_fall    = sck_prev & ~sck_now;

    // State register. If select is already low when reset releases, the
    // transaction in flight is unusable, so wait for the host to deselect.
    always_ff @(posedge clock_spi_in) begin
        if (reset_spi_in) begin
            state <= select_now ? IDLE : WAIT_DESELECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A high select forces IDLE from any state, so a
    // deselect wins over a byte that completes in the same cycle.
    always_comb begin
        state_next = state;
        if (select_now) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (select_fall) state_next = OPCODE;
                OPCODE:  if (sck_rise && bit_count == 3'd7) state_next = OPERAND;
                default: state_next = state;
            endcase
        end
    end

    // State decode for the datapath.
    always_comb begin
        receiving = 1'b0;
        in_opcode = 1'b0;
        case (state)
            OPCODE:  begin receiving = 1'b1; in_opcode = 1'b1; end
            OPERAND: receiving = 1'b1;
            default: begin receiving = 1'b0; in_opcode = 1'b0; end
        endcase
    end

    assign start     = (state == IDLE) && select_fall;
    assign byte_done = receiving && sck_rise && (bit_count == 3'd7);
    assign rx_byte   = {rx_shift, copi_now};

    // Receive shift register. It holds only the seven earlier bits of a byte,
    // because the eighth bit is taken straight from the synchroniser.
    always_ff @(posedge clock_spi_in) begin
        if (receiving && sck_rise) begin
            rx_shift <= {rx_shift[5:0], copi_now};
        end
    end

    // Byte framing, output registers and the CIPO transmit shifter.
    always_ff @(posedge clock_spi_in) begin
        if (reset_spi_in) begin
            bit_count     <= 3'd0;
            tx_shift      <= 8'h00;
            load_pending  <= 1'b0;
            op_code       <= 8'h00;
            op_code_valid <= 1'b0;
            operand       <= 8'h00;
            operand_valid <= 1'b0;
            operand_count <= 32'd0;
        end else if (select_rise) begin
            bit_count     <= 3'd0;
            tx_shift      <= 8'h00;
            load_pending  <= 1'b0;
            op_code_valid <= 1'b0;
            operand_valid <= 1'b0;
            operand_count <= 32'd0;
        end else if (start) begin
            // The op-code byte never carries a response.
            bit_count    <= 3'd0;
            tx_shift     <= IDLE_RESPONSE;
            load_pending <= 1'b0;
        end else if (receiving) begin
            if (sck_rise) begin
                bit_count     <= bit_count + 3'd1;
                operand_valid <= 1'b0;
                if (byte_done) begin
                    load_pending <= 1'b1;
                    if (in_opcode) begin
                        op_code       <= rx_byte;
                        op_code_valid <= 1'b1;
                        operand_count <= 32'd0;
                    end else begin
                        operand       <= rx_byte;
                        operand_valid <= 1'b1;
                        operand_count <= operand_count + 32'd1;
                    end
                end
            end
            if (sck_fall) begin
                if (load_pending) begin
                    tx_shift     <= bus.response_valid_in ? bus.response_in : IDLE_RESPONSE;
                    load_pending <= 1'b0;
                end else begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    assign bus.spi_data_out      = tx_shift[7];
    assign bus.op_code_out       = op_code;
    assign bus.op_code_valid_out = op_code_valid;
    assign bus.operand_out       = operand;
    assign bus.operand_valid_out = operand_valid;
    assign bus.operand_count_out = operand_count;

endmodule

// File: tb/tb_spi_subperipheral.sv
// Scoreboard bench for spi_subperipheral. The stimulus process acts as the
// SPI host and pushes the expected bytes. A monitor process compares each
// byte the DUT presents against those expectations.
`timescale 1ns/1ps
module tb_spi_subperipheral;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #7 clk = ~clk;

    spi_subperipheral_if sif();

    spi_subperipheral #(
        .SYNC_STAGES  (2),
        .IDLE_RESPONSE(8'h00)
    ) dut (
        .clock_spi_in(clk),
        .reset_spi_in(rst),
        .bus         (sif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  exp_op[$];
    logic [7:0]  exp_opnd[$];
    logic [31:0] exp_cnt[$];
    logic [7:0]  exp_cipo[$];
    logic [7:0]  obs_cipo[$];
    logic        resp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic select_low();
        sif.spi_select_in = 1'b0;
        wait_cycles(6);
    endtask

    // Shift nbits of tx MSB first and capture CIPO just before each rise.
    task automatic shift_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sif.spi_data_in = tx[i];
            wait_cycles(5);
            rx = {rx[6:0], sif.spi_data_out};
            sif.spi_clock_in = 1'b1;
            wait_cycles(5);
            sif.spi_clock_in = 1'b0;
        end
        sif.spi_data_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] tx);
        logic [7:0] rx;
        shift_bits(tx, 8, rx);
        obs_cipo.push_back(rx);
    endtask

    task automatic deselect(input int high_cycles);
        wait_cycles(5);
        sif.spi_select_in = 1'b1;
        wait_cycles(high_cycles);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_op_code"},       {24'd0, sif.op_code_out},       32'h0);
        check({tag, "_op_valid"},      {31'd0, sif.op_code_valid_out}, 32'h0);
        check({tag, "_operand"},       {24'd0, sif.operand_out},       32'h0);
        check({tag, "_operand_valid"}, {31'd0, sif.operand_valid_out}, 32'h0);
        check({tag, "_count"},         sif.operand_count_out,          32'h0);
        check({tag, "_cipo"},          {31'd0, sif.spi_data_out},      32'h0);
    endtask

    // Command-block model: a response keyed on the operand count, updated
    // once per cycle.
    initial begin
        sif.response_in       = 8'h00;
        sif.response_valid_in = 1'b0;
        forever begin
            @(negedge clk);
            sif.response_valid_in = resp_en;
            case (sif.operand_count_out)
                32'd0:   sif.response_in = 8'h9C;
                32'd1:   sif.response_in = 8'h40;
                default: sif.response_in = 8'h00;
            endcase
        end
    end

    // Monitor: compare on every rising valid and every completed CIPO byte.
    logic op_v_q   = 1'b0;
    logic opnd_v_q = 1'b0;
    always @(negedge clk) begin
        if (sif.op_code_valid_out && !op_v_q) begin
            if (exp_op.size() == 0) begin
                check("op_unexpected", {24'd0, sif.op_code_out}, 32'hFFFF_FFFF);
            end else begin
                check("op_code", {24'd0, sif.op_code_out}, {24'd0, exp_op.pop_front()});
                check("op_count_zero", sif.operand_count_out, 32'd0);
            end
        end
        if (sif.operand_valid_out && !opnd_v_q) begin
            if (exp_opnd.size() == 0) begin
                check("operand_unexpected", {24'd0, sif.operand_out}, 32'hFFFF_FFFF);
            end else begin
                check("operand", {24'd0, sif.operand_out}, {24'd0, exp_opnd.pop_front()});
                check("operand_count", sif.operand_count_out, exp_cnt.pop_front());
                check("op_valid_held", {31'd0, sif.op_code_valid_out}, 32'd1);
            end
        end
        while (obs_cipo.size() > 0) begin
            if (exp_cipo.size() == 0) begin
                check("cipo_unexpected", {24'd0, obs_cipo.pop_front()}, 32'hFFFF_FFFF);
            end else begin
                check("cipo_byte", {24'd0, obs_cipo.pop_front()}, {24'd0, exp_cipo.pop_front()});
            end
        end
        op_v_q   <= sif.op_code_valid_out;
        opnd_v_q <= sif.operand_valid_out;
    end

    initial begin
        logic [7:0] junk;
        sif.spi_select_in = 1'b1;
        sif.spi_clock_in  = 1'b0;
        sif.spi_data_in   = 1'b0;

        // Reset for two cycles with the pins idle.
        wait_cycles(2);
        check_all_zero("reset");
        rst = 1'b0;
        wait_cycles(4);

        // Read with two operands; the responder answers 0x9C then 0x40.
        resp_en = 1'b1;
        exp_op.push_back(8'h21);
        exp_opnd.push_back(8'hAA); exp_cnt.push_back(32'd1);
        exp_opnd.push_back(8'h55); exp_cnt.push_back(32'd2);
        exp_cipo.push_back(8'h00); exp_cipo.push_back(8'h9C); exp_cipo.push_back(8'h40);
        select_low();
        send_byte(8'h21); send_byte(8'hAA); send_byte(8'h55);
        check("count_end", sif.operand_count_out, 32'd2);
        deselect(6);

        // No valid response, so every CIPO byte is the idle response.
        resp_en = 1'b0;
        exp_op.push_back(8'h22);
        exp_opnd.push_back(8'h11); exp_cnt.push_back(32'd1);
        exp_opnd.push_back(8'h22); exp_cnt.push_back(32'd2);
        exp_opnd.push_back(8'h33); exp_cnt.push_back(32'd3);
        for (int i = 0; i < 4; i++) exp_cipo.push_back(8'h00);
        select_low();
        send_byte(8'h22); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        deselect(6);

        // Deselect five bits into the first operand; the partial byte is dropped.
        resp_en = 1'b1;
        exp_op.push_back(8'h23);
        exp_cipo.push_back(8'h00);
        select_low();
        send_byte(8'h23);
        shift_bits(8'hF0, 5, junk);
        wait_cycles(5);
        sif.spi_select_in = 1'b1;
        wait_cycles(4);
        check("abort_op_valid", {31'd0, sif.op_code_valid_out}, 32'd0);
        check("abort_count", sif.operand_count_out, 32'd0);
        check("abort_operand_valid", {31'd0, sif.operand_valid_out}, 32'd0);
        check("abort_op_kept", {24'd0, sif.op_code_out}, 32'h23);
        wait_cycles(4);
        exp_op.push_back(8'h20);
        exp_cipo.push_back(8'h00);
        select_low();
        send_byte(8'h20);
        deselect(6);

        // Reset pulse mid-operand with select held low.
        resp_en = 1'b0;
        exp_op.push_back(8'h24);
        exp_cipo.push_back(8'h00);
        select_low();
        send_byte(8'h24);
        shift_bits(8'hC3, 4, junk);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        check_all_zero("midreset");
        shift_bits(8'h3C, 4, junk);
        shift_bits(8'h99, 8, junk);
        check("midreset_op_valid", {31'd0, sif.op_code_valid_out}, 32'd0);
        check("midreset_count", sif.operand_count_out, 32'd0);
        deselect(6);
        exp_op.push_back(8'h21);
        exp_cipo.push_back(8'h00);
        select_low();
        send_byte(8'h21);
        deselect(6);

        // Back-to-back transactions separated by a four-cycle select gap.
        exp_op.push_back(8'h20);
        exp_cipo.push_back(8'h00);
        select_low();
        send_byte(8'h20);
        wait_cycles(5);
        sif.spi_select_in = 1'b1;
        wait_cycles(4);
        check("gap_op_valid", {31'd0, sif.op_code_valid_out}, 32'd0);
        exp_op.push_back(8'h22);
        exp_opnd.push_back(8'h00); exp_cnt.push_back(32'd1);
        exp_cipo.push_back(8'h00); exp_cipo.push_back(8'h00);
        select_low();
        send_byte(8'h22); send_byte(8'h00);
        check("b2b_op_code", {24'd0, sif.op_code_out}, 32'h22);
        deselect(6);

        wait_cycles(10);
        check("exp_op_left",   exp_op.size(),   0);
        check("exp_opnd_left", exp_opnd.size(), 0);
        check("exp_cipo_left", exp_cipo.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_subperipheral.md
# spi_subperipheral

Converts the host's SPI bus (mode 0, MSB first, active-low select) into the byte-level op-code/operand/response interface that the command-handling blocks (camera and peers) consume. It sits between the FPGA SPI pins and every command block. It oversamples the SPI pins in the 72 MHz SPI clock domain, frames the first byte of each transaction as an op-code and later bytes as operands, and serialises the block's response byte onto CIPO during the following byte.

## Interface
- SYNC_STAGES, 2, flip-flop stages on each SPI input pin before edge detection (≥2).
- IDLE_RESPONSE, 8'h00, byte shifted out when no valid response is presented.

- clock_spi_in  input  1  72 MHz system SPI-domain clock; only clock.
- reset_spi_in  input  1  synchronous, active-high reset.
- spi_select_in  input  1  chip select from host, active low, asynchronous.
- spi_clock_in  input  1  SCK from host, idle low, asynchronous.
- spi_data_in  input  1  COPI, sampled on SCK rising edge.
- spi_data_out  output  1  CIPO, changes on SCK falling edge.
- op_code_out  output  8  first byte of current transaction.
- op_code_valid_out  output  1  high from op-code completion until deselect.
- operand_out  output  8  most recently completed operand byte.
- operand_valid_out  output  1  high from operand completion until next byte's first SCK rise or deselect.
- operand_count_out  output  32  index of operand byte currently being shifted; also selects response.
- response_in  input  8  response byte from command block.
- response_valid_in  input  1  response_in is meaningful.

## Operation
- Synchronise select, SCK and COPI through SYNC_STAGES flops; one further flop per signal gives edge detection. All decisions use synchronised values.
- States:
  - IDLE: select high.
  - OPCODE: select low, first byte.
  - OPERAND: later bytes.
  - WAIT_DESELECT: entered when reset releases with select low; SCK ignored until select seen high.
- Transitions:
  - IDLE→OPCODE on synchronised select fall.
  - OPCODE→OPERAND on 8th SCK rise.
  - OPERAND stays until deselect.
  - Any state→IDLE on select rise, except WAIT_DESELECT→IDLE on select high.
- Receive: on each detected SCK rise, shift COPI into an 8-bit register (MSB first) and increment 3-bit bit counter. On counter wrap (8th rise), byte completes:
  - In OPCODE: op_code_out←byte, op_code_valid_out←1, operand_count_out←0.
  - In OPERAND: operand_out←byte, operand_valid_out←1, operand_count_out←operand_count_out+1 (mod 2^32).
- operand_valid_out clears on the first SCK rise of the next byte, or on deselect.
- Transmit: spi_data_out = tx_shift[7].
  - On select fall, tx_shift←IDLE_RESPONSE (op-code byte carries no response).
  - On the first SCK fall after a byte completes, tx_shift←response_in if response_valid_in else IDLE_RESPONSE.
  - On every other SCK fall, shift left, filling 0.
- Deselect (select rise), any state: op_code_valid_out, operand_valid_out, operand_count_out, bit counter→0; partial byte discarded, no valid asserted; spi_data_out←0. op_code_out/operand_out keep last value.
- Reset: all outputs 0, state IDLE, or WAIT_DESELECT if synchronised select is low at release.

## Timing
- Pin→detected edge: SYNC_STAGES+1 cycles. Detected 8th SCK rise at cycle N → op_code_valid_out/operand_valid_out/operand_count_out updated at N+1.
- Command blocks must present response_in/response_valid_in by N+2 (one registered cycle). The response is latched at the detected SCK fall, required ≥ N+3.
- Host limits:
  - SCK high ≥4 and low ≥4 clock_spi_in cycles (SCK ≤ 9 MHz).
  - Select fall to first SCK rise ≥4 cycles.
  - Last SCK fall to select rise ≥4 cycles.
  - Select high between transactions ≥4 cycles.
- Simultaneous select rise and 8th SCK rise in the same cycle: deselect wins; byte discarded.
- CIPO update lags pin SCK fall by SYNC_STAGES+2 cycles; must settle before the next rising edge (guaranteed by the high/low ≥4 rule).

## Test plan
- Reset: assert reset_spi_in 2 cycles with pins idle → all outputs 0, spi_data_out 0; first transaction after release decodes normally.
- Read two-byte count: op 0x21, operands 0xAA 0x55; responder returns 0x9C when count=0 and 0x40 when count=1 → CIPO bytes 0x00, 0x9C, 0x40.
  - op_code_out=0x21 with valid high throughout.
  - operand_valid pulses twice, operand_out 0xAA then 0x55, count ends at 2.
- response_valid_in held 0, op 0x22 with 3 operands → CIPO 0x00 ×4; three operand_valid rising edges.
- Select rises after 5 bits of the first operand → no operand_valid; op_code_valid_out and count return to 0 within SYNC_STAGES+2 cycles.
  - Next transaction, op 0x20, decodes as op-code 0x20.
- reset_spi_in pulsed mid-operand with select low → outputs 0 the next cycle; further SCK edges ignored.
  - After select high ≥4 cycles, then low, op 0x21 decodes correctly.
- Back-to-back: op 0x20 (no operands), select high 4 cycles, op 0x22 with operand 0x00 → op_code_out 0x20 then 0x22; op_code_valid_out low during the gap.
